// File: rtl/playback_addr_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | playback_addr_sequencer_if : keyboard, tick and memory-read signal bundle |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface playback_addr_sequencer_if #(
  parameter int ADDR_W  = 23,
  parameter int SPEED_W = 3
);
  logic               tick;
  logic               key_valid;
  logic [7:0]         keystroke;
  logic               read_ack;
  logic               read_req;
  logic [ADDR_W-1:0]  addr;
  logic               dir;
  logic               paused;
  logic [SPEED_W-1:0] speed;
  logic               done;
  logic               overrun;

  modport master (
    input  tick, key_valid, keystroke, read_ack,
    output read_req, addr, dir, paused, speed, done, overrun
  );

  modport slave (
    output tick, key_valid, keystroke, read_ack,
    input  read_req, addr, dir, paused, speed, done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/playback_addr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | playback_addr_sequencer : keyboard-controlled sample read-address stepper |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module playback_addr_sequencer #(
  parameter int          ADDR_W     = 23,
  parameter int unsigned FIRST_ADDR = 0,
  parameter int unsigned LAST_ADDR  = 'h7FFFF,
  parameter int          SPEED_W    = 3,
  parameter bit          LOOP       = 1'b1
) (
  input wire logic                  clk,
  input wire logic                  reset,
  playback_addr_sequencer_if.master bus
);
  typedef enum logic [1:0] {
    ST_WAIT_TICK = 2'd0,
    ST_REQ       = 2'd1,
    ST_PAUSED    = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]    c_first     = (ADDR_W+1)'(FIRST_ADDR);
  localparam logic [ADDR_W:0]    c_last      = (ADDR_W+1)'(LAST_ADDR);
  localparam logic [SPEED_W-1:0] c_speed_max = '1;
  localparam logic [SPEED_W-1:0] c_speed_min = SPEED_W'(1);

  state_t             r_state, w_state_n;
  logic [ADDR_W-1:0]  r_addr, w_addr_n;
  logic               r_dir, w_dir_n;
  logic [SPEED_W-1:0] r_speed, w_speed_n;
  logic               r_read_req, r_paused, r_done, r_overrun;
  logic               r_pend_pause, w_pend_pause_n;
  logic               r_pend_restart, w_pend_restart_n;
  logic               w_done_n, w_overrun_n;
  logic               w_key_pause, w_key_resume, w_key_fwd, w_key_bwd;
  logic               w_key_restart, w_key_up, w_key_down;
  logic [ADDR_W:0]    w_sum, w_back_lim;
  logic [ADDR_W-1:0]  w_step_addr, w_restart_addr;
  logic               w_hit_end;

  always_comb begin
    w_key_pause   = bus.key_valid && (bus.keystroke == 8'h44);
    w_key_resume  = bus.key_valid && (bus.keystroke == 8'h45);
    w_key_fwd     = bus.key_valid && (bus.keystroke == 8'h46);
    w_key_bwd     = bus.key_valid && (bus.keystroke == 8'h42);
    w_key_restart = bus.key_valid && (bus.keystroke == 8'h52);
    w_key_up      = bus.key_valid && (bus.keystroke == 8'h55);
    w_key_down    = bus.key_valid && (bus.keystroke == 8'h53);
  end

  // Direction and speed keys act at once, so a step taken in the same cycle uses the new values.
  always_comb begin
    w_dir_n = r_dir;
    if (w_key_fwd)      w_dir_n = 1'b1;
    else if (w_key_bwd) w_dir_n = 1'b0;

    w_speed_n = r_speed;
    if (w_key_up && (r_speed != c_speed_max))
      w_speed_n = r_speed + SPEED_W'(1);
    else if (w_key_down && (r_speed != c_speed_min))
      w_speed_n = r_speed - SPEED_W'(1);

    w_restart_addr = w_dir_n ? c_first[ADDR_W-1:0] : c_last[ADDR_W-1:0];
  end

  // End detection carries one extra bit so addr + speed cannot wrap unnoticed.
  always_comb begin
    w_sum       = {1'b0, r_addr} + (ADDR_W+1)'(w_speed_n);
    w_back_lim  = c_first + (ADDR_W+1)'(w_speed_n);
    w_hit_end   = 1'b0;
    w_step_addr = r_addr;
    if (w_dir_n) begin
      if (w_sum > c_last) begin
        w_hit_end   = 1'b1;
        w_step_addr = LOOP ? c_first[ADDR_W-1:0] : c_last[ADDR_W-1:0];
      end else begin
        w_step_addr = w_sum[ADDR_W-1:0];
      end
    end else begin
      if ({1'b0, r_addr} < w_back_lim) begin
        w_hit_end   = 1'b1;
        w_step_addr = LOOP ? c_last[ADDR_W-1:0] : c_first[ADDR_W-1:0];
      end else begin
        w_step_addr = r_addr - ADDR_W'(w_speed_n);
      end
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_addr_n         = r_addr;
    w_pend_pause_n   = r_pend_pause;
    w_pend_restart_n = r_pend_restart;
    w_done_n         = 1'b0;
    w_overrun_n      = 1'b0;
    case (r_state)
      ST_WAIT_TICK: begin
        // A pause arriving with a tick wins; the tick is silently dropped.
        if (w_key_pause) begin
          w_state_n = ST_PAUSED;
        end else begin
          if (w_key_restart) w_addr_n = w_restart_addr;
          if (bus.tick)      w_state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        w_overrun_n      = bus.tick;
        w_pend_pause_n   = r_pend_pause | w_key_pause;
        w_pend_restart_n = r_pend_restart | w_key_restart;
        if (bus.read_ack) begin
          w_pend_pause_n   = 1'b0;
          w_pend_restart_n = 1'b0;
          w_state_n        = ST_WAIT_TICK;
          if (r_pend_restart || w_key_restart) begin
            w_addr_n = w_restart_addr;
          end else begin
            w_addr_n = w_step_addr;
            if (w_hit_end && !LOOP) begin
              w_state_n = ST_PAUSED;
              w_done_n  = 1'b1;
            end
          end
          if (r_pend_pause || w_key_pause) w_state_n = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (w_key_resume)  w_state_n = ST_WAIT_TICK;
        if (w_key_restart) w_addr_n  = w_restart_addr;
      end
      default: w_state_n = ST_WAIT_TICK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_WAIT_TICK;
      r_addr         <= c_first[ADDR_W-1:0];
      r_dir          <= 1'b1;
      r_speed        <= c_speed_min;
      r_read_req     <= 1'b0;
      r_paused       <= 1'b0;
      r_done         <= 1'b0;
      r_overrun      <= 1'b0;
      r_pend_pause   <= 1'b0;
      r_pend_restart <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_addr         <= w_addr_n;
      r_dir          <= w_dir_n;
      r_speed        <= w_speed_n;
      r_read_req     <= (w_state_n == ST_REQ);
      r_paused       <= (w_state_n == ST_PAUSED);
      r_done         <= w_done_n;
      r_overrun      <= w_overrun_n;
      r_pend_pause   <= w_pend_pause_n;
      r_pend_restart <= w_pend_restart_n;
    end
  end

  assign bus.read_req = r_read_req;
  assign bus.addr     = r_addr;
  assign bus.dir      = r_dir;
  assign bus.paused   = r_paused;
  assign bus.speed    = r_speed;
  assign bus.done     = r_done;
  assign bus.overrun  = r_overrun;
endmodule
`default_nettype wire
